// File: rtl/inbuf_loader.sv
// inbuf_loader: accepts rows over a valid/ready handshake, writes them to LANES parallel INBUFs, then drains them.
// Optional: define INBUF_LOADER_ZPAD_EN to zero-pad tiles closed by in_last up to DEPTH rows before draining.
module inbuf_loader #(
    parameter int LANES = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [LANES*DW-1:0]        in_data,
    input  logic                       in_last,
    output logic                       buf_write,
    output logic [LANES*DW-1:0]        buf_din,
    output logic                       buf_read,
    input  logic [LANES-1:0]           buf_empty,
    output logic [$clog2(DEPTH+1)-1:0] rows,
    output logic                       done
);
    localparam int RW = $clog2(DEPTH + 1);
    localparam logic [RW-1:0] FULL = RW'(DEPTH);

`ifdef INBUF_LOADER_ZPAD_EN
    typedef enum logic [2:0] { IDLE, LOAD, DRAIN, DONE, PAD } state_t;
`else
    typedef enum logic [1:0] { IDLE, LOAD, DRAIN, DONE } state_t;
`endif

    state_t                state_q, state_d;
    logic [RW-1:0]         rows_q, rows_d;
    logic                  wr_q, wr_d;
    logic [LANES*DW-1:0]   din_q, din_d;
    logic                  rd_q, rd_d;
    logic                  done_q, done_d;
    logic                  rdy_q, rdy_d;
    logic                  fire;

    assign fire = in_valid && rdy_q;

    always_comb begin
        state_d = state_q;
        rows_d  = rows_q;
        wr_d    = 1'b0;
        din_d   = din_q;
        rd_d    = 1'b0;
        if (fire) begin
            wr_d  = 1'b1;
            din_d = in_data;
            if (rows_q != FULL) rows_d = rows_q + RW'(1);
        end
        unique case (state_q)
            IDLE, LOAD: begin
                if (fire) begin
`ifdef INBUF_LOADER_ZPAD_EN
                    if (in_last && rows_d != FULL)
                        state_d = PAD;
                    else if (in_last || rows_d == FULL)
                        state_d = DRAIN;
                    else
                        state_d = LOAD;
`else
                    if (in_last || rows_d == FULL)
                        state_d = DRAIN;
                    else
                        state_d = LOAD;
`endif
                end
            end
`ifdef INBUF_LOADER_ZPAD_EN
            PAD: begin
                wr_d   = 1'b1;
                din_d  = '0;
                rows_d = rows_q + RW'(1);
                if (rows_d == FULL) state_d = DRAIN;
            end
`endif
            // First DRAIN cycle leaves room for the last write to land.
            DRAIN: begin
                if (rd_q && (&buf_empty))
                    state_d = DONE;
                else
                    rd_d = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                rows_d  = '0;
            end
            default: state_d = IDLE;
        endcase
        done_d = (state_d == DONE);
        rdy_d  = (state_d == IDLE) ||
                 ((state_d == LOAD) && (rows_d != FULL));
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            rows_q  <= '0;
            wr_q    <= 1'b0;
            din_q   <= '0;
            rd_q    <= 1'b0;
            done_q  <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rows_q  <= rows_d;
            wr_q    <= wr_d;
            din_q   <= din_d;
            rd_q    <= rd_d;
            done_q  <= done_d;
            rdy_q   <= rdy_d;
        end
    end

    assign in_ready  = rdy_q;
    assign buf_write = wr_q;
    assign buf_din   = din_q;
    assign buf_read  = rd_q;
    assign rows      = rows_q;
    assign done      = done_q;
endmodule

// File: tb/tb_inbuf_loader.sv
// Testbench for inbuf_loader: tile-level reference model with an INBUF occupancy model.
// Expectations follow INBUF_LOADER_ZPAD_EN when it is defined for the build.
module tb_inbuf_loader;
    localparam int LANES = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int W     = LANES * DW;
    localparam int RW    = $clog2(DEPTH + 1);

    logic           clk = 1'b0;
    logic           rstn;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic           in_last;
    logic           buf_write;
    logic [W-1:0]   buf_din;
    logic           buf_read;
    logic [LANES-1:0] buf_empty;
    logic [RW-1:0]  rows;
    logic           done;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    inbuf_loader #(.LANES(LANES), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last),
        .buf_write(buf_write), .buf_din(buf_din),
        .buf_read(buf_read), .buf_empty(buf_empty),
        .rows(rows), .done(done)
    );

    // INBUF environment: occupancy counter; lane 0 may report empty one row early.
    int occ;
    int skew = 0;
    int wtot = 0, rtot = 0, both = 0, dtot = 0;
    int rd_rows = 0;
    logic rd_prev;
    logic [W-1:0] obs_w [0:4095];

    assign buf_empty = {{(LANES-1){occ == 0}}, (occ <= skew)};

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ     <= 0;
            rd_prev <= 1'b0;
        end else begin
            if (buf_write && wtot < 4096) obs_w[wtot] <= buf_din;
            if (buf_write) wtot <= wtot + 1;
            if (buf_read) rtot <= rtot + 1;
            if (buf_write && buf_read) both <= both + 1;
            if (done) dtot <= dtot + 1;
            if (buf_read && !rd_prev) rd_rows <= int'(rows);
            rd_prev <= buf_read;
            occ <= occ + (buf_write ? 1 : 0) - ((buf_read && occ > 0) ? 1 : 0);
        end
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        nchk++;
        assert (o === e) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    logic [W-1:0] dir_data [0:2];

    task automatic run_tile(input int n, input bit use_last, input int pct,
                            input bit dir, input int sk, input bit abort);
        int acc = 0, cyc = 0, fin, w0, r0, b0, d0;
        bit v, l, got = 1'b0;
        logic [W-1:0] d;
        logic [W-1:0] ew [$];
        skew = sk;
        w0 = wtot; r0 = rtot; b0 = both;
        fin = n;
`ifdef INBUF_LOADER_ZPAD_EN
        if (use_last && n < DEPTH) fin = DEPTH;
`endif
        while (acc < n && cyc < 500) begin
            v = (pct < 0) ? (cyc % 2 == 0) : ($urandom_range(99) < pct);
            d = (dir && acc < 3) ? dir_data[acc] : W'($urandom);
            l = use_last && (acc == n - 1);
            in_valid = v;
            in_data  = d;
            in_last  = v ? l : 1'($urandom_range(1));
            chk("ready_load", in_ready, 1);
            @(posedge clk); #1;
            if (v) begin
                ew.push_back(d);
                acc++;
            end
            chk("write", buf_write, v);
            if (v) chk("din", buf_din, d);
            chk("rows_load", rows, acc);
            cyc++;
        end
        chk("load_bound", acc, n);
        if (abort) begin
            in_valid = 1'b0;
            cyc = 0;
            while (buf_read !== 1'b1 && cyc < 100) begin
                @(posedge clk); #1;
                cyc++;
            end
            chk("read_started", buf_read, 1);
            d0 = dtot;
            rstn = 1'b0;
            #1;
            chk("rst_read", buf_read, 0);
            chk("rst_write", buf_write, 0);
            chk("rst_rows", rows, 0);
            chk("rst_ready", in_ready, 0);
            @(posedge clk); #1;
            chk("rst_done", done, 0);
            rstn = 1'b1;
            @(posedge clk); #1;
            chk("rel_ready", in_ready, 1);
            chk("rel_done", done, 0);
            chk("no_done_pulse", dtot, d0);
            return;
        end
        for (int i = n; i < fin; i++) ew.push_back('0);
        cyc = 0;
        while (!got && cyc < 1000) begin
            in_valid = 1'b1;
            in_data  = W'($urandom);
            in_last  = 1'($urandom_range(1));
            chk("ready_drain", in_ready, 0);
            @(posedge clk); #1;
            if (done === 1'b1) got = 1'b1;
            cyc++;
        end
        chk("done_seen", got, 1);
        chk("rows_done", rows, fin);
        chk("rows_at_read", rd_rows, fin);
        chk("read_cycles", rtot - r0, fin + 1);
        chk("write_count", wtot - w0, fin);
        for (int i = 0; i < fin && i < wtot - w0; i++)
            chk("wdata", obs_w[w0 + i], ew[i]);
        chk("wr_rd_overlap", both, b0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("done_single", done, 0);
        chk("rows_clear", rows, 0);
        chk("ready_idle", in_ready, 1);
    endtask

    initial begin
        int n;
        bit lst;
        dir_data[0] = 32'h01020304;
        dir_data[1] = 32'h05060708;
        dir_data[2] = 32'h090A0B0C;
        rstn     = 1'b0;
        in_valid = 1'b1;
        in_data  = 32'hDEADBEEF;
        in_last  = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready0", in_ready, 0);
        chk("rst_write0", buf_write, 0);
        chk("rst_read0", buf_read, 0);
        chk("rst_done0", done, 0);
        chk("rst_rows0", rows, 0);
        chk("rst_din0", buf_din, 0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready0", in_ready, 1);
        chk("rel_write0", buf_write, 0);
        chk("rel_rows0", rows, 0);
        in_valid = 1'b0;
        in_last  = 1'b0;

        run_tile(3, 1'b1, 100, 1'b1, 0, 1'b0);
        run_tile(DEPTH, 1'b0, 100, 1'b0, 1, 1'b0);
        run_tile(6, 1'b1, -1, 1'b0, 0, 1'b0);
        run_tile(1, 1'b1, 100, 1'b0, 1, 1'b0);
        run_tile(4, 1'b1, 100, 1'b0, 0, 1'b1);
        run_tile(5, 1'b1, 80, 1'b0, 0, 1'b0);
        for (int t = 0; t < 6; t++) begin
            n   = $urandom_range(DEPTH, 1);
            lst = (n < DEPTH) ? 1'b1 : 1'($urandom_range(1));
            run_tile(n, lst, $urandom_range(100, 30), 1'b0,
                     $urandom_range(1), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
